// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Two-requester arbiter and access sequencer for the shared DRAM array.
//   Port 0 is instruction fetch, port 1 is load/store. One request is
//   accepted at a time. The DRAM addr/wdata/write_enable are driven for
//   ACCESS_CYCLES cycles, rdata is sampled on the last access cycle, and a
//   one-cycle response pulse is returned to the granted port.
//
// Ports
//   clk, rst                : clock; asynchronous active-low reset
//   reqN_valid/addr/wdata/we: request from port N (N = 0, 1)
//   reqN_ready              : request accepted this cycle (combinational)
//   rspN_valid/rdata        : completion pulse and last read data for port N
//   mem_addr/wdata/we       : to the DRAM instance
//   mem_rdata               : from the DRAM instance
//   busy                    : sequencer is not idle
//
// Optional build macro DRAM_ARBITER_STATS_EN adds saturating 16-bit
// counters grant_cnt0, grant_cnt1 and stall_cnt.
module dram_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_we,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_we,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef DRAM_ARBITER_STATS_EN
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1,
    output logic [15:0]           stall_cnt,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_port_q, gnt_port_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic win_valid;
    logic win_port;
    logic accept;

    // Round-robin on ties: the port that did not win last time goes first.
    always_comb begin
        win_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            win_port = ~last_grant_q;
        end else begin
            win_port = req1_valid;
        end
    end

    // rst is folded in so no ready is shown while reset is held.
    always_comb begin
        req0_ready = rst && (state_q == IDLE) && win_valid && !win_port;
        req1_ready = rst && (state_q == IDLE) && win_valid &&  win_port;
        accept     = req0_ready | req1_ready;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching, access counter and read-data capture
    always_comb begin
        last_grant_d = last_grant_q;
        gnt_port_d   = gnt_port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        if (accept) begin
            last_grant_d = win_port;
            gnt_port_d   = win_port;
            we_d         = win_port ? req1_we    : req0_we;
            addr_d       = win_port ? req1_addr  : req0_addr;
            wdata_d      = win_port ? req1_wdata : req0_wdata;
            cnt_d        = CNT_INIT;
        end
        if (state_q == ACCESS) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else if (!we_q) begin
                if (gnt_port_q) rdata1_d = mem_rdata;
                else            rdata0_d = mem_rdata;
            end
        end
    end

    // Outputs; mem_we is decoded from state so an async reset drops it at once.
    always_comb begin
        mem_we     = (state_q == ACCESS) && we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        rsp0_valid = (state_q == RESP) && !gnt_port_q;
        rsp1_valid = (state_q == RESP) &&  gnt_port_q;
        rsp0_rdata = rdata0_q;
        rsp1_rdata = rdata1_q;
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_port_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 4'd0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_port_q   <= gnt_port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef DRAM_ARBITER_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;
    logic [15:0] stall_cnt_q,  stall_cnt_d;
    logic        stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // One stall per cycle no matter how many ports are waiting.
    always_comb begin
        stall        = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
        grant_cnt0_d = sat_inc(grant_cnt0_q, req0_ready);
        grant_cnt1_d = sat_inc(grant_cnt1_q, req1_ready);
        stall_cnt_d  = sat_inc(stall_cnt_q, stall);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    always_comb begin
        grant_cnt0 = grant_cnt0_q;
        grant_cnt1 = grant_cnt1_q;
        stall_cnt  = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: instance 0 built with ACCESS_CYCLES=1, instance 1
// with ACCESS_CYCLES=3, each with its own small DRAM array. A timeline-based
// reference model (free-at cycle, access window, response cycle) predicts
// every output of both instances in every cycle.
`timescale 1ns/1ps
module tb_dram_arbiter;
    localparam int AC0 = 1;
    localparam int AC1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        rv  [2][2];
    logic        rwe [2][2];
    logic [31:0] ra  [2][2];
    logic [31:0] rw  [2][2];
    logic        rdy [2][2];
    logic        sv  [2][2];
    logic [31:0] srd [2][2];
    logic [31:0] maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] mrd [2];
    logic        mwe [2];
    logic        bsy [2];
`ifdef DRAM_ARBITER_STATS_EN
    logic [15:0] gc0 [2];
    logic [15:0] gc1 [2];
    logic [15:0] sc  [2];
`endif
    logic [31:0] dram [2][16];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                for (int a = 0; a < 16; a++) dram[i][a] <= 32'd0;
            end else if (mwe[i]) begin
                dram[i][maddr[i][3:0]] <= mwd[i];
            end
        end
    end
    assign mrd[0] = dram[0][maddr[0][3:0]];
    assign mrd[1] = dram[1][maddr[1][3:0]];

    dram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACCESS_CYCLES(AC0)) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0][0]), .req0_addr(ra[0][0]), .req0_wdata(rw[0][0]), .req0_we(rwe[0][0]),
        .req0_ready(rdy[0][0]), .rsp0_valid(sv[0][0]), .rsp0_rdata(srd[0][0]),
        .req1_valid(rv[0][1]), .req1_addr(ra[0][1]), .req1_wdata(rw[0][1]), .req1_we(rwe[0][1]),
        .req1_ready(rdy[0][1]), .rsp1_valid(sv[0][1]), .rsp1_rdata(srd[0][1]),
        .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_we(mwe[0]), .mem_rdata(mrd[0]),
`ifdef DRAM_ARBITER_STATS_EN
        .grant_cnt0(gc0[0]), .grant_cnt1(gc1[0]), .stall_cnt(sc[0]),
`endif
        .busy(bsy[0])
    );

    dram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACCESS_CYCLES(AC1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(rv[1][0]), .req0_addr(ra[1][0]), .req0_wdata(rw[1][0]), .req0_we(rwe[1][0]),
        .req0_ready(rdy[1][0]), .rsp0_valid(sv[1][0]), .rsp0_rdata(srd[1][0]),
        .req1_valid(rv[1][1]), .req1_addr(ra[1][1]), .req1_wdata(rw[1][1]), .req1_we(rwe[1][1]),
        .req1_ready(rdy[1][1]), .rsp1_valid(sv[1][1]), .rsp1_rdata(srd[1][1]),
        .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_we(mwe[1]), .mem_rdata(mrd[1]),
`ifdef DRAM_ARBITER_STATS_EN
        .grant_cnt0(gc0[1]), .grant_cnt1(gc1[1]), .stall_cnt(sc[1]),
`endif
        .busy(bsy[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state (per instance)
    int          free_at   [2];
    int          acc_start [2];
    int          rsp_cyc   [2];
    int          rsp_port  [2];
    bit          cur_we    [2];
    logic [31:0] cur_addr  [2];
    int          last_g    [2];
    logic [31:0] e_maddr   [2];
    logic [31:0] e_mwd     [2];
    logic [31:0] e_rd      [2][2];
    logic [31:0] mm        [2][16];
    int          e_gc0     [2];
    int          e_gc1     [2];
    int          e_sc      [2];

    // Observations of the cycle just completed by step()
    logic        last_rdy   [2][2];
    logic        last_rsp   [2][2];
    logic        last_mwe   [2];
    logic        last_busy  [2];
    logic [31:0] last_maddr [2];

    task automatic model_reset(input int i);
        free_at[i]   = cyc;
        acc_start[i] = -1000;
        rsp_cyc[i]   = -1000;
        rsp_port[i]  = 0;
        cur_we[i]    = 1'b0;
        cur_addr[i]  = 32'd0;
        last_g[i]    = 1;
        e_maddr[i]   = 32'd0;
        e_mwd[i]     = 32'd0;
        e_rd[i][0]   = 32'd0;
        e_rd[i][1]   = 32'd0;
        for (int a = 0; a < 16; a++) mm[i][a] = 32'd0;
        e_gc0[i] = 0;
        e_gc1[i] = 0;
        e_sc[i]  = 0;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                rv[i][p] = 1'b0; rwe[i][p] = 1'b0; ra[i][p] = 32'd0; rw[i][p] = 32'd0;
            end
        end
    endtask

    // One clock cycle: called at a falling edge with inputs set; checks both
    // instances against the model, advances the model, returns at the next
    // falling edge.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            int       ac;
            int       win;
            bit       idle;
            bit       stall;
            logic [5:0] ectl;
            logic [5:0] octl;
            ac = (i == 0) ? AC0 : AC1;
            if (!rst) model_reset(i);
            idle = rst && (cyc >= free_at[i]);
            win = -1;
            if (idle) begin
                if (rv[i][0] && rv[i][1]) win = 1 - last_g[i];
                else if (rv[i][0])        win = 0;
                else if (rv[i][1])        win = 1;
            end
            if (rst && cyc == rsp_cyc[i] && !cur_we[i])
                e_rd[i][rsp_port[i]] = mm[i][cur_addr[i][3:0]];
            ectl = {(win == 0), (win == 1),
                    (rst && cyc == rsp_cyc[i] && rsp_port[i] == 0),
                    (rst && cyc == rsp_cyc[i] && rsp_port[i] == 1),
                    (rst && cur_we[i] && cyc >= acc_start[i] && cyc < acc_start[i] + ac),
                    (rst && cyc < free_at[i])};
            octl = {rdy[i][0], rdy[i][1], sv[i][0], sv[i][1], mwe[i], bsy[i]};
            checks++;
            if (octl !== ectl) begin
                errors++;
                $display("FAIL ctl inst%0d cyc%0d {rdy0,rdy1,rsp0,rsp1,we,busy}: got %b want %b",
                         i, cyc, octl, ectl);
            end
            checks++;
            if ({maddr[i], mwd[i]} !== {e_maddr[i], e_mwd[i]}) begin
                errors++;
                $display("FAIL membus inst%0d cyc%0d: got addr %h wdata %h want addr %h wdata %h",
                         i, cyc, maddr[i], mwd[i], e_maddr[i], e_mwd[i]);
            end
            checks++;
            if ({srd[i][0], srd[i][1]} !== {e_rd[i][0], e_rd[i][1]}) begin
                errors++;
                $display("FAIL rdata inst%0d cyc%0d: got %h %h want %h %h",
                         i, cyc, srd[i][0], srd[i][1], e_rd[i][0], e_rd[i][1]);
            end
`ifdef DRAM_ARBITER_STATS_EN
            checks++;
            if ({gc0[i], gc1[i], sc[i]} !== {16'(e_gc0[i]), 16'(e_gc1[i]), 16'(e_sc[i])}) begin
                errors++;
                $display("FAIL stats inst%0d cyc%0d: got %0d %0d %0d want %0d %0d %0d",
                         i, cyc, gc0[i], gc1[i], sc[i], e_gc0[i], e_gc1[i], e_sc[i]);
            end
`endif
            last_rdy[i][0] = rdy[i][0];
            last_rdy[i][1] = rdy[i][1];
            last_rsp[i][0] = sv[i][0];
            last_rsp[i][1] = sv[i][1];
            last_mwe[i]    = mwe[i];
            last_busy[i]   = bsy[i];
            last_maddr[i]  = maddr[i];
            if (rst) begin
                stall = (rv[i][0] && win != 0) || (rv[i][1] && win != 1);
                if (stall && e_sc[i] < 65535) e_sc[i]++;
                if (win >= 0) begin
                    last_g[i]    = win;
                    acc_start[i] = cyc + 1;
                    rsp_cyc[i]   = cyc + ac + 1;
                    free_at[i]   = cyc + ac + 2;
                    rsp_port[i]  = win;
                    cur_we[i]    = rwe[i][win];
                    cur_addr[i]  = ra[i][win];
                    e_maddr[i]   = ra[i][win];
                    e_mwd[i]     = rw[i][win];
                    if (rwe[i][win]) mm[i][ra[i][win][3:0]] = rw[i][win];
                    if (win == 0 && e_gc0[i] < 65535) e_gc0[i]++;
                    if (win == 1 && e_gc1[i] < 65535) e_gc1[i]++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_quiet(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++)
                    if (rv[i][p] && last_rdy[i][p]) rv[i][p] = 1'b0;
            if (!rv[0][0] && !rv[0][1] && !rv[1][0] && !rv[1][1] && !bsy[0] && !bsy[1]) begin
                checks++;
                return;
            end
            step();
        end
        checks++;
        errors++;
        $display("FAIL quiet: still busy after %0d cycles, want idle", maxc);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    rv[i][p]  = 1'($urandom_range(0, 1));
                    rwe[i][p] = 1'($urandom_range(0, 1));
                    ra[i][p]  = $urandom;
                    rw[i][p]  = $urandom;
                end
            #1;
            checks++;
            if ({rdy[0][0], rdy[0][1], rdy[1][0], rdy[1][1], sv[0][0], sv[0][1], sv[1][0], sv[1][1],
                 mwe[0], mwe[1], bsy[0], bsy[1]} !== 12'd0) begin
                errors++;
                $display("FAIL reset_ctl: got nonzero control outputs, want all 0");
            end
            checks++;
            if ((maddr[0] | maddr[1] | mwd[0] | mwd[1] | srd[0][0] | srd[0][1] | srd[1][0] | srd[1][1]) !== 32'd0) begin
                errors++;
                $display("FAIL reset_data: got nonzero data outputs, want all 0");
            end
            step();
        end
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i][0] = 1'b1;
            rv[i][1] = 1'b1;
        end
        #1;
        checks++;
        if ({rdy[0][0], rdy[0][1], rdy[1][0], rdy[1][1]} !== 4'b1010) begin
            errors++;
            $display("FAIL first_tie: got ready %b%b%b%b want 1010",
                     rdy[0][0], rdy[0][1], rdy[1][0], rdy[1][1]);
        end
        step();
        run_until_quiet(40);
    endtask

    task automatic test_contention();
        int ord [4];
        int adr [4];
        int g;
        int nrsp0;
        int nrsp1;
        bit capture;
        int exp_ord [4];
        int exp_adr [4];
        exp_ord = '{0, 1, 0, 1};
        exp_adr = '{1, 2, 1, 2};
        g = 0; nrsp0 = 0; nrsp1 = 0; capture = 1'b0;
        for (int k = 0; k < 4; k++) begin ord[k] = -1; adr[k] = -1; end
        clear_inputs();
        ra[0][0] = 32'd1; ra[0][1] = 32'd2;
        rv[0][0] = 1'b1;  rv[0][1] = 1'b1;
        for (int n = 0; n < 14; n++) begin
            step();
            if (capture) begin adr[g-1] = int'(last_maddr[0]); capture = 1'b0; end
            if (last_rsp[0][0]) nrsp0++;
            if (last_rsp[0][1]) nrsp1++;
            if ((last_rdy[0][0] || last_rdy[0][1]) && g < 4) begin
                ord[g] = last_rdy[0][1] ? 1 : 0;
                g++;
                capture = 1'b1;
                if (g == 4) begin rv[0][0] = 1'b0; rv[0][1] = 1'b0; end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ord[k] !== exp_ord[k]) begin
                errors++;
                $display("FAIL grant_order[%0d]: got %0d want %0d", k, ord[k], exp_ord[k]);
            end
            checks++;
            if (adr[k] !== exp_adr[k]) begin
                errors++;
                $display("FAIL mem_addr_seq[%0d]: got %0d want %0d", k, adr[k], exp_adr[k]);
            end
        end
        checks++;
        if (nrsp0 !== 2 || nrsp1 !== 2) begin
            errors++;
            $display("FAIL rsp_counts: got %0d/%0d want 2/2", nrsp0, nrsp1);
        end
        run_until_quiet(20);
    endtask

    task automatic test_write_read();
        run_until_quiet(20);
        clear_inputs();
        rv[0][0] = 1'b1; rwe[0][0] = 1'b1; ra[0][0] = 32'd5; rw[0][0] = 32'hA5;
        #1;
        checks++;
        if (rdy[0][0] !== 1'b1) begin
            errors++; $display("FAIL wr_ready: got %b want 1", rdy[0][0]);
        end
        step();
        rv[0][0] = 1'b0;
        #1;
        checks++;
        if ({mwe[0], sv[0][0]} !== 2'b10) begin
            errors++; $display("FAIL wr_k1: got we,rsp %b%b want 10", mwe[0], sv[0][0]);
        end
        step();
        #1;
        checks++;
        if ({mwe[0], sv[0][0], sv[0][1]} !== 3'b010) begin
            errors++; $display("FAIL wr_k2: got we,rsp0,rsp1 %b%b%b want 010", mwe[0], sv[0][0], sv[0][1]);
        end
        step();
        rv[0][0] = 1'b1; rwe[0][0] = 1'b0; ra[0][0] = 32'd5; rw[0][0] = 32'd0;
        step();
        rv[0][0] = 1'b0;
        step();
        #1;
        checks++;
        if ({sv[0][0], sv[0][1], srd[0][0]} !== {1'b1, 1'b0, 32'hA5}) begin
            errors++;
            $display("FAIL rd_resp: got rsp0 %b rsp1 %b rdata %h want 1 0 000000a5", sv[0][0], sv[0][1], srd[0][0]);
        end
        step();
    endtask

    task automatic test_access3();
        logic [2:0] exp3 [5];
        int nwe;
        exp3 = '{3'b110, 3'b110, 3'b110, 3'b011, 3'b000};
        nwe = 0;
        run_until_quiet(20);
        clear_inputs();
        rv[1][1] = 1'b1; rwe[1][1] = 1'b1; ra[1][1] = 32'd9; rw[1][1] = 32'h3C;
        #1;
        checks++;
        if (rdy[1][1] !== 1'b1) begin
            errors++; $display("FAIL ac3_ready: got %b want 1", rdy[1][1]);
        end
        step();
        rv[1][1] = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            #1;
            if (mwe[1]) nwe++;
            checks++;
            if ({mwe[1], bsy[1], sv[1][1]} !== exp3[j-1]) begin
                errors++;
                $display("FAIL ac3_k%0d {we,busy,rsp1}: got %b%b%b want %b", j, mwe[1], bsy[1], sv[1][1], exp3[j-1]);
            end
            step();
        end
        checks++;
        if (nwe !== 3) begin
            errors++; $display("FAIL ac3_we_cycles: got %0d want 3", nwe);
        end
        rv[1][1] = 1'b1; rwe[1][1] = 1'b0; ra[1][1] = 32'd9;
        step();
        run_until_quiet(20);
        #1;
        checks++;
        if (srd[1][1] !== 32'h3C) begin
            errors++; $display("FAIL ac3_read: got %h want 0000003c", srd[1][1]);
        end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    if (rv[i][p] && last_rdy[i][p]) begin
                        rv[i][p] = 1'b0;
                    end else if (rv[i][p]) begin
                        if ($urandom_range(0, 9) == 0) rv[i][p] = 1'b0;
                    end else if ($urandom_range(0, 1) == 1) begin
                        rv[i][p]  = 1'b1;
                        ra[i][p]  = {28'd0, 4'($urandom_range(0, 15))};
                        rw[i][p]  = $urandom;
                        rwe[i][p] = 1'($urandom_range(0, 1));
                    end
                end
            step();
        end
        run_until_quiet(40);
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        rv[1][1] = 1'b1; rwe[1][1] = 1'b1; ra[1][1] = 32'd7; rw[1][1] = 32'h77;
        step();
        rv[1][1] = 1'b0;
        step();
        #1;
        checks++;
        if (mwe[1] !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got we %b want 1", mwe[1]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mwe[1], bsy[1]} !== 2'b00) begin
            errors++; $display("FAIL mid_abort: got we,busy %b%b want 00", mwe[1], bsy[1]);
        end
        step();
        step();
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (last_rsp[1][1] !== 1'b0) begin
                errors++; $display("FAIL mid_no_rsp: got rsp1 1 want 0");
            end
        end
        rv[1][0] = 1'b1; rv[1][1] = 1'b1;
        #1;
        checks++;
        if ({rdy[1][0], rdy[1][1]} !== 2'b10) begin
            errors++; $display("FAIL mid_tie: got ready %b%b want 10", rdy[1][0], rdy[1][1]);
        end
        step();
        run_until_quiet(40);
    endtask

`ifdef DRAM_ARBITER_STATS_EN
    task automatic test_stats();
        int seq [3];
        seq = '{0, 0, 1};
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rv[0][seq[k]] = 1'b1;
            step();
            rv[0][seq[k]] = 1'b0;
            step();
            step();
        end
        rv[0][0] = 1'b1; rv[0][1] = 1'b1;
        step();
        rv[0][0] = 1'b0;
        step();
        step();
        step();
        rv[0][1] = 1'b0;
        step();
        step();
        #1;
        checks++;
        if ({gc0[0], gc1[0], sc[0]} !== {16'd3, 16'd2, 16'd3}) begin
            errors++;
            $display("FAIL stats_counts: got %0d %0d %0d want 3 2 3", gc0[0], gc1[0], sc[0]);
        end
        rv[1][0] = 1'b1; rv[1][1] = 1'b1;
        for (int n = 0; n < 65540; n++) step();
        #1;
        checks++;
        if (sc[1] !== 16'hFFFF) begin
            errors++; $display("FAIL stall_sat: got %h want ffff", sc[1]);
        end
        clear_inputs();
        run_until_quiet(20);
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            last_rdy[i][0] = 1'b0; last_rdy[i][1] = 1'b0;
            last_rsp[i][0] = 1'b0; last_rsp[i][1] = 1'b0;
            last_mwe[i] = 1'b0; last_busy[i] = 1'b0; last_maddr[i] = 32'd0;
        end
        #2 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_contention();
        test_write_read();
        test_access3();
        test_random();
        test_reset_mid();
`ifdef DRAM_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
